// File: rtl/cva5_fifo_counted_pkg.sv
// Shared helpers for the counted FIFO.
// Pointer wrap is expressed once here so storage indexing and pointer logic agree.
package cva5_fifo_counted_pkg;

   function automatic logic is_last_index(input int unsigned idx, input int unsigned depth);
      return idx == depth - 1;
   endfunction

endpackage

// File: rtl/lutram_1w_1r.sv
// Distributed-RAM style storage: one synchronous write port, one asynchronous read port.
// Exactly DEPTH entries; addresses at or above DEPTH are never presented by the owner.
module lutram_1w_1r #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 6
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/cva5_fifo_counted.sv
// Single-clock FIFO of arbitrary depth with occupancy count, almost-full threshold,
// high-water mark, synchronous flush and sticky overflow/underflow flags.
module cva5_fifo_counted
   import cva5_fifo_counted_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int FIFO_DEPTH   = 6,
   parameter int AF_THRESHOLD = FIFO_DEPTH - 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             push,
   input  logic [DATA_WIDTH-1:0]            data_in,
   input  logic                             pop,
   input  logic                             flush,
   output logic [DATA_WIDTH-1:0]            data_out,
   output logic                             valid,
   output logic                             full,
   output logic                             almost_full,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  high_water,
   output logic                             overflow,
   output logic                             underflow
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESHOLD);

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          clear;
   logic          pop_acc;
   logic          push_acc;
   logic [CW:0]   count_ext;
   logic [CW-1:0] count_next;

   // Handshake: push/pop are requests, not held transactions. A request is taken in the
   // cycle it is asserted or dropped (flagging overflow/underflow); there is no retry.
   // A pop frees a slot in the same cycle, so push+pop while full is accepted.
   assign clear    = rst | flush;
   assign pop_acc  = pop & valid & ~clear;
   assign push_acc = push & (~full | pop_acc) & ~clear;

   assign count_ext  = {1'b0, count} + (CW+1)'(push_acc) - (CW+1)'(pop_acc);
   assign count_next = count_ext[CW-1:0];

   assign valid       = (count != '0);
   assign full        = (count == DEPTH_C);
   assign almost_full = (count >= AF_C);

   always_ff @(posedge clk) begin
      if (clear) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         high_water <= '0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (pop_acc)
            rd_ptr <= is_last_index(32'(rd_ptr), FIFO_DEPTH) ? '0 : rd_ptr + PW'(1);
         if (push_acc)
            wr_ptr <= is_last_index(32'(wr_ptr), FIFO_DEPTH) ? '0 : wr_ptr + PW'(1);
         count      <= count_next;
         high_water <= (count_next > high_water) ? count_next : high_water;
         overflow   <= overflow  | (push & ~push_acc);
         underflow  <= underflow | (pop & ~pop_acc);
      end
   end

   lutram_1w_1r #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) storage (
      .clk   (clk),
      .we    (push_acc),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (data_out)
   );

   // Dropped requests are legal but worth seeing in simulation logs.
   always_ff @(posedge clk) begin
      if (!clear) begin
         if (push & full & ~pop) $warning("cva5_fifo_counted: push dropped while full");
         if (pop & ~valid)       $warning("cva5_fifo_counted: pop ignored while empty");
         assert (count <= DEPTH_C) else $error("cva5_fifo_counted: count above depth");
         assert (count_ext <= {1'b0, DEPTH_C}) else $error("cva5_fifo_counted: next count above depth");
      end
   end

endmodule

// File: tb/tb_cva5_fifo_counted.sv
// Self-checking bench for cva5_fifo_counted (depth 6, width 32, almost-full at 5).
// A queue model tracks contents; a vector table pins the fill/drain sequence explicitly.
module tb_cva5_fifo_counted;

   localparam int DW = 32;
   localparam int DEPTH = 6;
   localparam int AF = 5;

   logic          clk = 1'b0;
   logic          rst, push, pop, flush;
   logic [DW-1:0] data_in, data_out;
   logic          valid, full, almost_full, overflow, underflow;
   logic [2:0]    count, high_water;

   int n_checks = 0;
   int n_fail = 0;

   logic [DW-1:0] exp_q[$];
   int            m_hw;
   logic          m_ovf, m_unf;

   typedef struct {
      logic          push;
      logic          pop;
      logic [DW-1:0] din;
      logic [2:0]    e_count;
      logic          e_full;
      logic          e_af;
      logic [2:0]    e_hw;
      logic [DW-1:0] e_head;
   } vec_t;
   vec_t vecs[12];

   cva5_fifo_counted #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESHOLD(AF)) dut (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .data_in     (data_in),
      .pop         (pop),
      .flush       (flush),
      .data_out    (data_out),
      .valid       (valid),
      .full        (full),
      .almost_full (almost_full),
      .count       (count),
      .high_water  (high_water),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_model();
      check("count", 32'(count), 32'(exp_q.size()));
      check("valid", 32'(valid), 32'(exp_q.size() != 0));
      check("full", 32'(full), 32'(exp_q.size() == DEPTH));
      check("almost_full", 32'(almost_full), 32'(exp_q.size() >= AF));
      check("high_water", 32'(high_water), 32'(m_hw));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_unf));
      if (exp_q.size() != 0) check("head", data_out, exp_q[0]);
   endtask

   // Drive one cycle from the negedge, update the model, then check at the next negedge.
   task automatic step(input logic r, input logic p, input logic q, input logic f,
                       input logic [DW-1:0] d);
      logic pa, qa;
      rst = r; push = p; pop = q; flush = f; data_in = d;
      if (r || f) begin
         exp_q.delete();
         m_hw = 0; m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
         qa = q && (exp_q.size() != 0);
         pa = p && ((exp_q.size() != DEPTH) || qa);
         if (p && !pa) m_ovf = 1'b1;
         if (q && !qa) m_unf = 1'b1;
         if (qa) begin
            check("pop_data", data_out, exp_q[0]);
            void'(exp_q.pop_front());
         end
         if (pa) exp_q.push_back(d);
         if (exp_q.size() > m_hw) m_hw = exp_q.size();
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0;
      check_model();
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; data_in = '0;
      exp_q.delete(); m_hw = 0; m_ovf = 1'b0; m_unf = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_model();

      // Fill A0..A5 then drain; expected values written out by hand.
      vecs[0]  = '{1'b1, 1'b0, 32'hA0, 3'd1, 1'b0, 1'b0, 3'd1, 32'hA0};
      vecs[1]  = '{1'b1, 1'b0, 32'hA1, 3'd2, 1'b0, 1'b0, 3'd2, 32'hA0};
      vecs[2]  = '{1'b1, 1'b0, 32'hA2, 3'd3, 1'b0, 1'b0, 3'd3, 32'hA0};
      vecs[3]  = '{1'b1, 1'b0, 32'hA3, 3'd4, 1'b0, 1'b0, 3'd4, 32'hA0};
      vecs[4]  = '{1'b1, 1'b0, 32'hA4, 3'd5, 1'b0, 1'b1, 3'd5, 32'hA0};
      vecs[5]  = '{1'b1, 1'b0, 32'hA5, 3'd6, 1'b1, 1'b1, 3'd6, 32'hA0};
      vecs[6]  = '{1'b0, 1'b1, 32'h00, 3'd5, 1'b0, 1'b1, 3'd6, 32'hA1};
      vecs[7]  = '{1'b0, 1'b1, 32'h00, 3'd4, 1'b0, 1'b0, 3'd6, 32'hA2};
      vecs[8]  = '{1'b0, 1'b1, 32'h00, 3'd3, 1'b0, 1'b0, 3'd6, 32'hA3};
      vecs[9]  = '{1'b0, 1'b1, 32'h00, 3'd2, 1'b0, 1'b0, 3'd6, 32'hA4};
      vecs[10] = '{1'b0, 1'b1, 32'h00, 3'd1, 1'b0, 1'b0, 3'd6, 32'hA5};
      vecs[11] = '{1'b0, 1'b1, 32'h00, 3'd0, 1'b0, 1'b0, 3'd6, 32'h00};
      for (int i = 0; i < 12; i++) begin
         step(1'b0, vecs[i].push, vecs[i].pop, 1'b0, vecs[i].din);
         check("tbl_count", 32'(count), 32'(vecs[i].e_count));
         check("tbl_full", 32'(full), 32'(vecs[i].e_full));
         check("tbl_af", 32'(almost_full), 32'(vecs[i].e_af));
         check("tbl_hw", 32'(high_water), 32'(vecs[i].e_hw));
         check("tbl_valid", 32'(valid), 32'(vecs[i].e_count != 0));
         if (vecs[i].e_count != 0) check("tbl_head", data_out, vecs[i].e_head);
      end

      // Wrap-around: hold count at 3 with 20 push+pop cycles.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h10 + i);
      check("wrap_first", data_out, 32'h10);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h13 + i);
      check("wrap_count", 32'(count), 32'd3);

      // Push while full, then push+pop while full.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'($urandom_range(0, 255)));
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD);
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_count", 32'(count), 32'd6);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'hBEEF);
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("full_pp_count", 32'(count), 32'd6);

      // Flush at count 4 with a concurrent push and overflow set.
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h5555);
      check("flush_count", 32'(count), 32'd0);
      check("flush_ovf", 32'(overflow), 32'd0);
      check("flush_hw", 32'(high_water), 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h77);
      check("post_flush_head", data_out, 32'h77);

      // Empty boundary: pop while empty, then push+pop while empty.
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      check("unf_set", 32'(underflow), 32'd1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h99);
      check("empty_pp_count", 32'(count), 32'd1);
      check("empty_pp_head", data_out, 32'h99);

      // Reset mid-stream at count 3, then a single push.
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h2);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h3);
      check("rst_count", 32'(count), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_unf", 32'(underflow), 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'hC3);
      check("rst_push_valid", 32'(valid), 32'd1);
      check("rst_push_head", data_out, 32'hC3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
